// File: rtl/i2s_tdm_tx_pkg.sv
// Shared types and helpers for the i2s_tdm_tx serial audio transmitter.
package i2s_tdm_tx_pkg;

  typedef enum logic [1:0] {
    FMT_I2S = 2'd0,
    FMT_LJ  = 2'd1,
    FMT_RJ  = 2'd2
  } audio_fmt_t;

  function automatic int frame_bits(input int channels, input int slot_w);
    return channels * slot_w;
  endfunction

  function automatic int slot_of(input int pos, input int slot_w);
    return pos / slot_w;
  endfunction

endpackage

// File: rtl/i2s_tdm_tx_if.sv
// Frame handshake between the core mixer (master) and the serial transmitter (slave).
interface i2s_tdm_tx_if
  import i2s_tdm_tx_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 16
);

  logic [CHANNELS*SAMPLE_W-1:0] sample_data;
  logic                         sample_valid;
  logic                         sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);

endinterface

// File: rtl/i2s_tdm_tx_bclk_gen.sv
// Bit-clock divider: toggles bck every CLK_DIV clk_sys cycles and flags the falling edge.
module i2s_tdm_tx_bclk_gen
  import i2s_tdm_tx_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic bck,
  output logic bck_fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tc;

  // bck_fall is high in the cycle whose edge drives bck low, so callers update in lockstep
  assign tc       = (cnt == CW'(CLK_DIV - 1));
  assign bck_fall = tc & bck;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      bck <= 1'b0;
    end else if (tc) begin
      cnt <= '0;
      bck <= ~bck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2s_tdm_tx.sv
// I2S / left- / right-justified stereo or TDM transmitter with a one-frame buffer and underrun repeat.
module i2s_tdm_tx
  import i2s_tdm_tx_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int CHANNELS = 2,
  parameter int CLK_DIV  = 8,
  parameter int MODE     = 0
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  i2s_tdm_tx_if.slave   bus,
  output logic          frame_start,
  output logic          underrun,
  output logic          I2S_BCK,
  output logic          I2S_LRCK,
  output logic          I2S_DATA
);

  localparam int FB = frame_bits(CHANNELS, SLOT_W);
  localparam int FW = CHANNELS * SAMPLE_W;
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BW = $clog2(SLOT_W);
  localparam audio_fmt_t FMT = audio_fmt_t'(MODE[1:0]);

  if (SAMPLE_W < 8 || SAMPLE_W > 32 || SAMPLE_W > SLOT_W) begin : g_bad_sample_w
    $error("i2s_tdm_tx: SAMPLE_W=%0d invalid for SLOT_W=%0d", SAMPLE_W, SLOT_W);
  end
  if (SLOT_W < 16 || SLOT_W > 32) begin : g_bad_slot_w
    $error("i2s_tdm_tx: SLOT_W=%0d out of range", SLOT_W);
  end
  if (CHANNELS < 2 || CHANNELS > 8) begin : g_bad_channels
    $error("i2s_tdm_tx: CHANNELS=%0d out of range", CHANNELS);
  end
  if (CLK_DIV < 1 || MODE < 0 || MODE > 2 || FB < 2) begin : g_bad_misc
    $error("i2s_tdm_tx: CLK_DIV=%0d MODE=%0d invalid", CLK_DIV, MODE);
  end

  logic          bck_fall;
  logic [SW-1:0] slot_cnt, slot_nxt, slot_src;
  logic [BW-1:0] bit_cnt, bit_nxt, bit_src;
  logic [FW-1:0] buf_data, cur_frame, frame_nxt;
  logic          buf_full, load_pt, lrck_nxt, data_nxt;

  i2s_tdm_tx_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .bck      (I2S_BCK),
    .bck_fall (bck_fall)
  );

  // Bit presented at slot s, in-slot bit b of a frame, for LJ/RJ layout
  function automatic logic fmt_bit(input logic [FW-1:0] frame, input logic [SW-1:0] s,
                                   input logic [BW-1:0] b);
    logic [SAMPLE_W-1:0] smp;
    logic [SAMPLE_W-1:0] sh;
    int                  k;
    smp = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (s == SW'(c)) smp = frame[c*SAMPLE_W +: SAMPLE_W];
    end
    k = int'(b);
    if (FMT == FMT_RJ) k = k - (SLOT_W - SAMPLE_W);
    sh = smp << k;
    if (k < 0)              return smp[SAMPLE_W-1];
    else if (k >= SAMPLE_W) return 1'b0;
    else                    return sh[SAMPLE_W-1];
  endfunction

  // I2S content trails the position by one BCK, so it reuses the pre-advance position
  always_comb begin
    slot_nxt = slot_cnt;
    bit_nxt  = bit_cnt + BW'(1);
    if (bit_cnt == BW'(SLOT_W - 1)) begin
      bit_nxt  = '0;
      slot_nxt = (slot_cnt == SW'(CHANNELS - 1)) ? '0 : slot_cnt + SW'(1);
    end
    if (FMT == FMT_I2S) load_pt = (slot_nxt == '0) && (bit_nxt == BW'(1));
    else                load_pt = (slot_nxt == '0) && (bit_nxt == '0);
    frame_nxt = (load_pt && buf_full) ? buf_data : cur_frame;
    slot_src  = (FMT == FMT_I2S) ? slot_cnt : slot_nxt;
    bit_src   = (FMT == FMT_I2S) ? bit_cnt  : bit_nxt;
    data_nxt  = fmt_bit(frame_nxt, slot_src, bit_src);
    if (CHANNELS == 2) lrck_nxt = (slot_nxt == SW'(1));
    else               lrck_nxt = (slot_nxt == '0) && (bit_nxt == '0);
  end

  assign bus.sample_ready = ~buf_full;

  // cur_frame doubles as the last-frame copy that is replayed on underrun
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt    <= SW'(CHANNELS - 1);
      bit_cnt     <= BW'(SLOT_W - 1);
      buf_data    <= '0;
      buf_full    <= 1'b0;
      cur_frame   <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      I2S_LRCK    <= 1'b0;
      I2S_DATA    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (bus.sample_valid && !buf_full) begin
        buf_data <= bus.sample_data;
        buf_full <= 1'b1;
      end
      if (bck_fall) begin
        slot_cnt  <= slot_nxt;
        bit_cnt   <= bit_nxt;
        cur_frame <= frame_nxt;
        I2S_LRCK  <= lrck_nxt;
        I2S_DATA  <= data_nxt;
        if (load_pt) begin
          frame_start <= 1'b1;
          if (buf_full) buf_full <= 1'b0;
          else          underrun <= 1'b1;
        end
      end
    end
  end

endmodule
